// File: rtl/arbitro_rr_fifos_pkg.sv
// Shared definitions for the 4-lane round-robin FIFO merger: arbiter state encodings,
// lane count and default data width.
package arbitro_rr_fifos_pkg;

   localparam int NUM_LANES  = 4;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_STALL  = 2'd3
   } arb_state_t;

   // Lane index reached by stepping 'off' lanes from 'base', wrapping mod NUM_LANES.
   function automatic logic [1:0] next_lane(input logic [1:0] base, input logic [1:0] off);
      return base + off;
   endfunction

endpackage

// File: rtl/arbitro_rr_fifos_fifo_lane.sv
// Per-lane FIFO: DEPTH entries (power of 2), occupancy counter one bit wider than the pointers,
// flags derived from the registered count.
module fifo_lane #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              empty_next
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic              push_ok;
   logic              pop_ok;

   // A full lane still takes a word when the same edge frees a slot.
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;

   always_comb begin
      count_next = count;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   assign dout        = mem[rd_ptr];
   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almost_full = (count >= CW'(AF_THRESH));
   assign empty_next  = (count_next == '0);

endmodule

// File: rtl/arbitro_rr_fifos.sv
// Four buffered lanes merged round-robin onto one registered output, with per-lane pause and
// downstream backpressure. Optional drop counter enabled by defining DROP_COUNT_EN.
module arbitro_rr_fifos
   import arbitro_rr_fifos_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   input  logic              valid_in3,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic              full_down,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [3:0]        pause,
   output logic [3:0]        empty,
`ifdef DROP_COUNT_EN
   output logic [7:0]        drop_cnt,
`endif
   output logic [1:0]        state
);

   // Handshake: a lane word is taken at the edge where valid_inI=1 and the lane has room (or pops
   // that same edge); there is no ready back-channel, pause[I] is an advisory almost-full. On the
   // output, valid_out qualifies data_out for exactly one cycle and full_down=1 blocks all grants.

   logic [3:0]        valid_in;
   logic [DATA_W-1:0] din   [NUM_LANES];
   logic [DATA_W-1:0] dout  [NUM_LANES];
   logic [3:0]        full;
   logic [3:0]        empty_nx;
   logic [3:0]        push;
   logic [3:0]        pop;
   logic [1:0]        rr_ptr;
   logic [1:0]        gnt_lane;
   logic [1:0]        idx;
   logic              found;
   logic              gnt_valid;
   logic              any_ne;
   logic              any_ne_next;
   arb_state_t        state_q;
   arb_state_t        state_d;

   assign valid_in = {valid_in3, valid_in2, valid_in1, valid_in0};
   assign din[0]   = in0;
   assign din[1]   = in1;
   assign din[2]   = in2;
   assign din[3]   = in3;
   assign push     = valid_in & (~full | pop);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      fifo_lane #(
         .DATA_W    (DATA_W),
         .DEPTH     (DEPTH),
         .AF_THRESH (AF_THRESH)
      ) u_fifo (
         .clk         (clk),
         .reset_L     (reset_L),
         .push        (push[g]),
         .pop         (pop[g]),
         .din         (din[g]),
         .dout        (dout[g]),
         .full        (full[g]),
         .empty       (empty[g]),
         .almost_full (pause[g]),
         .empty_next  (empty_nx[g])
      );
   end

   // First non-empty lane at or after rr_ptr wins.
   always_comb begin
      found    = 1'b0;
      gnt_lane = rr_ptr;
      idx      = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = next_lane(rr_ptr, 2'(k));
         if (!found && !empty[idx]) begin
            found    = 1'b1;
            gnt_lane = idx;
         end
      end
      gnt_valid = found & ~full_down;
      pop       = gnt_valid ? (4'b0001 << gnt_lane) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         rr_ptr    <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= gnt_valid;
         if (gnt_valid) begin
            data_out <= dout[gnt_lane];
            rr_ptr   <= gnt_lane + 1'b1;
         end
      end
   end

   assign any_ne      = ~&empty;
   assign any_ne_next = ~&empty_nx;

   always_ff @(posedge clk) begin
      if (!reset_L) state_q <= ST_RESET;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_IDLE;
         ST_IDLE:   if (any_ne) state_d = full_down ? ST_STALL : ST_ACTIVE;
         ST_ACTIVE: begin
            if (full_down && any_ne) state_d = ST_STALL;
            else if (!any_ne_next)   state_d = ST_IDLE;
         end
         ST_STALL: begin
            if (!any_ne)         state_d = ST_IDLE;
            else if (!full_down) state_d = ST_ACTIVE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   assign state = state_q;

`ifdef DROP_COUNT_EN
   logic [3:0] drops;
   logic [2:0] drop_sum;
   logic [8:0] drop_acc;

   assign drops    = valid_in & full & ~pop;
   assign drop_sum = 3'(drops[0]) + 3'(drops[1]) + 3'(drops[2]) + 3'(drops[3]);
   assign drop_acc = {1'b0, drop_cnt} + {6'b0, drop_sum};

   always_ff @(posedge clk) begin
      if (!reset_L)          drop_cnt <= '0;
      else if (drop_acc[8])  drop_cnt <= 8'hFF;
      else                   drop_cnt <= drop_acc[7:0];
   end
`endif

endmodule
